// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single combinational-read byte-addressed RAM.
// It accepts one fetch (read-only) or data (read/write) request per transaction and returns a registered response.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_w_en,
  input  logic [DATA_W-1:0] d_req_w_data,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic [3:0]        ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_next;
  logic                last_grant_d;   // 1: data port won the most recent handshake
  logic                lat_port_d;
  logic [ADDR_W-1:0]   lat_addr;
  logic [3:0]          lat_w_en;
  logic [DATA_W-1:0]   lat_w_data;
  logic                err_q;
  logic                grant_d, grant_i;
  logic                handshake;
  logic                w_en_legal;

  // On a tie the data port wins under fixed priority, or when fetch went last.
  always_comb begin
    grant_d = d_req_valid & (~i_req_valid | DATA_PRIO | ~last_grant_d);
    grant_i = i_req_valid & ~grant_d;
  end

  assign handshake  = i_req_ready | d_req_ready;
  assign w_en_legal = (lat_w_en == 4'b0000) || (lat_w_en == 4'b0001) ||
                      (lat_w_en == 4'b0011) || (lat_w_en == 4'b1111);

  assign ram_addr   = lat_addr;
  assign ram_w_data = lat_w_data;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: each combinational output is given a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = handshake ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    d_resp_err   = 1'b0;
    ram_w_en     = 4'b0000;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        i_req_ready = grant_i;
        d_req_ready = grant_d;
      end
      ACCESS: begin
        busy     = 1'b1;
        ram_w_en = w_en_legal ? lat_w_en : 4'b0000;
      end
      RESP: begin
        i_req_ready  = grant_i;
        d_req_ready  = grant_d;
        i_resp_valid = ~lat_port_d;
        d_resp_valid = lat_port_d;
        d_resp_err   = lat_port_d & err_q;
      end
      default: ;
    endcase
  end

  // Request latch and response capture; the RAM commits its write on the same edge,
  // so the captured word is the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b1;
      lat_port_d   <= 1'b0;
      lat_addr     <= '0;
      lat_w_en     <= 4'b0000;
      lat_w_data   <= '0;
      err_q        <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      if (handshake) begin
        last_grant_d <= d_req_ready;
        lat_port_d   <= d_req_ready;
        lat_addr     <= d_req_ready ? d_req_addr   : i_req_addr;
        lat_w_en     <= d_req_ready ? d_req_w_en   : 4'b0000;
        lat_w_data   <= d_req_ready ? d_req_w_data : '0;
      end
      if (state == ACCESS) begin
        err_q <= lat_port_d & ~w_en_legal;
        if (lat_port_d) d_resp_data <= ram_r_data;
        else            i_resp_data <= ram_r_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural byte RAM, a vector table of
// single transactions, and hand-written reset-abort and arbitration sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [15:0] i_req_addr;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_err;
  logic [15:0] d_req_addr;
  logic [3:0]  d_req_w_en;
  logic [31:0] d_req_w_data, d_resp_data;
  logic [3:0]  ram_w_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic        busy;

  // Second instance with fixed data priority; its RAM returns the address.
  logic        p_i_req_valid, p_i_req_ready, p_i_resp_valid;
  logic [31:0] p_i_resp_data;
  logic        p_d_req_valid, p_d_req_ready, p_d_resp_valid, p_d_resp_err;
  logic [31:0] p_d_resp_data;
  logic [3:0]  p_ram_w_en;
  logic [15:0] p_ram_addr;
  logic [31:0] p_ram_w_data, p_ram_r_data;
  logic        p_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .DATA_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_w_en(d_req_w_en), .d_req_w_data(d_req_w_data),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .DATA_PRIO(1'b1)) u_dut_prio (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(p_i_req_valid), .i_req_ready(p_i_req_ready), .i_req_addr(16'h0100),
    .i_resp_valid(p_i_resp_valid), .i_resp_data(p_i_resp_data),
    .d_req_valid(p_d_req_valid), .d_req_ready(p_d_req_ready), .d_req_addr(16'h0200),
    .d_req_w_en(4'b0000), .d_req_w_data(32'h0),
    .d_resp_valid(p_d_resp_valid), .d_resp_data(p_d_resp_data), .d_resp_err(p_d_resp_err),
    .ram_w_en(p_ram_w_en), .ram_addr(p_ram_addr), .ram_w_data(p_ram_w_data),
    .ram_r_data(p_ram_r_data), .busy(p_busy)
  );

  assign p_ram_r_data = {16'h0000, p_ram_addr};

  // Behavioural RAM: combinational read, byte-lane write at the clock edge.
  logic [7:0]  mem [0:65535];
  logic [15:0] a1, a2, a3;
  always_comb begin
    a1 = ram_addr + 16'd1;
    a2 = ram_addr + 16'd2;
    a3 = ram_addr + 16'd3;
    ram_r_data = {mem[a3], mem[a2], mem[a1], mem[ram_addr]};
  end

  always @(posedge clk) begin
    if (ram_w_en[0]) mem[ram_addr] <= ram_w_data[7:0];
    if (ram_w_en[1]) mem[a1]       <= ram_w_data[15:8];
    if (ram_w_en[2]) mem[a2]       <= ram_w_data[23:16];
    if (ram_w_en[3]) mem[a3]       <= ram_w_data[31:24];
  end

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
    logic [3:0]  w_en;
    logic [31:0] w_data;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_ram_wen;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] w);
    mem[a]          = w[7:0];
    mem[a + 16'd1]  = w[15:8];
    mem[a + 16'd2]  = w[23:16];
    mem[a + 16'd3]  = w[31:24];
  endtask

  function automatic logic [31:0] peek(input logic [15:0] a);
    return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic do_txn(input vec_t v, input int idx);
    int waited;
    logic rdy;
    i_req_valid  = ~v.is_d;
    i_req_addr   = v.addr;
    d_req_valid  = v.is_d;
    d_req_addr   = v.addr;
    d_req_w_en   = v.w_en;
    d_req_w_data = v.w_data;
    waited = 0;
    #1;
    rdy = v.is_d ? d_req_ready : i_req_ready;
    while (!rdy && waited < 20) begin
      @(negedge clk); #1;
      waited++;
      rdy = v.is_d ? d_req_ready : i_req_ready;
    end
    check($sformatf("v%0d ready_wait", idx), waited, 0);
    check($sformatf("v%0d other_ready", idx), v.is_d ? i_req_ready : d_req_ready, 1'b0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d access_busy", idx), busy, 1'b1);
    check($sformatf("v%0d access_addr", idx), ram_addr, v.addr);
    check($sformatf("v%0d access_wen", idx), ram_w_en, v.exp_ram_wen);
    check($sformatf("v%0d access_no_resp", idx), {i_resp_valid, d_resp_valid}, 2'b00);
    @(negedge clk);
    check($sformatf("v%0d resp_valid", idx), {i_resp_valid, d_resp_valid}, v.is_d ? 2'b01 : 2'b10);
    check($sformatf("v%0d resp_data", idx), v.is_d ? d_resp_data : i_resp_data, v.exp_data);
    check($sformatf("v%0d resp_err", idx), d_resp_err, v.exp_err);
    check($sformatf("v%0d resp_wen", idx), {busy, ram_w_en}, 5'b0);
    @(negedge clk);
    check($sformatf("v%0d pulse_end", idx), {i_resp_valid, d_resp_valid, busy}, 3'b000);
    check($sformatf("v%0d data_hold", idx), v.is_d ? d_resp_data : i_resp_data, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_w_en = 0; d_req_w_data = 0;
    p_i_req_valid = 0; p_d_req_valid = 0;

    //              is_d  addr      w_en     w_data        exp_data      err   ram_wen
    vecs[0]  = '{1'b0, 16'h0000, 4'b0000, 32'h0,        32'h00000000, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'b1111};
    vecs[2]  = '{1'b0, 16'h0010, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000};
    vecs[3]  = '{1'b1, 16'h0020, 4'b0001, 32'h000000AB, 32'h11223344, 1'b0, 4'b0001};
    vecs[4]  = '{1'b1, 16'h0020, 4'b0011, 32'h0000CDEF, 32'h112233AB, 1'b0, 4'b0011};
    vecs[5]  = '{1'b1, 16'h0020, 4'b0000, 32'h0,        32'h1122CDEF, 1'b0, 4'b0000};
    vecs[6]  = '{1'b1, 16'h0050, 4'b0001, 32'h000000AB, 32'h11223344, 1'b0, 4'b0001};
    vecs[7]  = '{1'b1, 16'h0050, 4'b0000, 32'h0,        32'h112233AB, 1'b0, 4'b0000};
    vecs[8]  = '{1'b1, 16'h0030, 4'b0101, 32'hFFFFFFFF, 32'h55667788, 1'b1, 4'b0000};
    vecs[9]  = '{1'b1, 16'h0030, 4'b0000, 32'h0,        32'h55667788, 1'b0, 4'b0000};
    vecs[10] = '{1'b1, 16'hFFFE, 4'b1111, 32'h0A0B0C0D, 32'h00000000, 1'b0, 4'b1111};
    vecs[11] = '{1'b0, 16'hFFFE, 4'b0000, 32'h0,        32'h0A0B0C0D, 1'b0, 4'b0000};
    vecs[12] = '{1'b0, 16'h0000, 4'b0000, 32'h0,        32'h00000A0B, 1'b0, 4'b0000};
    vecs[13] = '{1'b1, 16'hFFFF, 4'b0000, 32'h0,        32'h000A0B0C, 1'b0, 4'b0000};

    preload(16'h0020, 32'h11223344);
    preload(16'h0050, 32'h11223344);
    preload(16'h0030, 32'h55667788);
    preload(16'h0060, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset resp_valid", {i_resp_valid, d_resp_valid, d_resp_err}, 3'b000);
    check("reset ram_wen", ram_w_en, 4'b0000);
    check("reset ram_addr", ram_addr, 16'h0000);
    check("reset i_resp_data", i_resp_data, 32'h0);
    check("reset d_resp_data", d_resp_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) do_txn(vecs[k], k);
    check("wrap mem[0xFFFE]", mem[16'hFFFE], 8'h0D);
    check("wrap mem[0x0001]", mem[16'h0001], 8'h0A);

    // Reset asserted while a write is in ACCESS: no write, no response.
    d_req_valid = 1'b1; d_req_addr = 16'h0060; d_req_w_en = 4'b1111; d_req_w_data = 32'h12345678;
    #1 check("abort ready", d_req_ready, 1'b1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    check("abort in_access", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy_cleared", busy, 1'b0);
    check("abort wen_cleared", ram_w_en, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort no_resp_in_reset%0d", k), {i_resp_valid, d_resp_valid}, 2'b00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort idle_after%0d", k), {busy, i_resp_valid, d_resp_valid}, 3'b000);
    end
    check("abort mem_unchanged", peek(16'h0060), 32'hCAFEF00D);
    check("abort d_resp_data_cleared", d_resp_data, 32'h0);

    // Both ports valid continuously from a fresh reset on both instances.
    i_req_valid = 1'b1; i_req_addr = 16'h0100;
    d_req_valid = 1'b1; d_req_addr = 16'h0200; d_req_w_en = 4'b0000; d_req_w_data = 32'h0;
    p_i_req_valid = 1'b1; p_d_req_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("rr cyc%0d i_ready", k), i_req_ready, (k % 4) == 0);
      check($sformatf("rr cyc%0d d_ready", k), d_req_ready, (k % 4) == 2);
      check($sformatf("prio cyc%0d i_ready", k), p_i_req_ready, 1'b0);
      check($sformatf("prio cyc%0d d_ready", k), p_d_req_ready, (k % 2) == 0);
      @(negedge clk);
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    p_i_req_valid = 1'b0; p_d_req_valid = 1'b0;
    check("rr last_resp_is_d", {i_resp_valid, d_resp_valid}, 2'b01);
    check("rr last_resp_data", d_resp_data, 32'h00000000);
    check("prio last_resp_data", p_d_resp_data, 32'h00000200);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
